// File: rtl/burst_line_adaptor_pkg.sv
// burst_line_adaptor: shared state type and sizing helpers.
// Sizing helpers keep the top and line_buffer in agreement.
package adaptor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } adaptor_state_t;

    function automatic int calc_beats(int line_w, int word_w);
        return line_w / word_w;
    endfunction

    function automatic int calc_idx_w(int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic int calc_ofs(int line_w);
        return $clog2(line_w / 8);
    endfunction

endpackage

// File: rtl/burst_line_adaptor_if.sv
// burst_line_adaptor: word-wide physical-memory port.
// master = adaptor side, slave = memory side.
interface burst_line_adaptor_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) ();

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_W-1:0]     mem_address;
    logic [WORD_W-1:0]     mem_wdata;
    logic [WORD_W/8-1:0]   mem_byte_enable;
    logic [WORD_W-1:0]     mem_rdata;
    logic                  mem_resp;

    modport master (
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_wdata,
        output mem_byte_enable,
        input  mem_rdata,
        input  mem_resp
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_wdata,
        input  mem_byte_enable,
        output mem_rdata,
        output mem_resp
    );

endinterface

// File: rtl/burst_line_adaptor_buffer.sv
// line_buffer: one cacheline register with full-line load,
// word-indexed write, word-indexed read mux and sync clear.
module line_buffer
    import adaptor_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int WORD_W = 32,
    localparam int BEATS = calc_beats(LINE_W, WORD_W),
    localparam int IDX_W = calc_idx_w(BEATS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load_en,
    input  logic [LINE_W-1:0] load_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_data,
    output logic [LINE_W-1:0] line
);

    logic [LINE_W-1:0] line_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            line_q <= '0;
        end else if (load_en) begin
            line_q <= load_data;
        end else if (wr_en) begin
            for (int k = 0; k < BEATS; k++) begin
                if (wr_idx == IDX_W'(k)) begin
                    line_q[k*WORD_W +: WORD_W] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (rd_idx == IDX_W'(k)) begin
                rd_data = line_q[k*WORD_W +: WORD_W];
            end
        end
    end

    assign line = line_q;

endmodule

// File: rtl/burst_line_adaptor.sv
// burst_line_adaptor: turns one cacheline request into a
// handshaked burst of word beats on the memory port.
module burst_line_adaptor
    import adaptor_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 line_read,
    input  logic                 line_write,
    input  logic [ADDR_W-1:0]    line_addr,
    input  logic [LINE_W-1:0]    line_wdata,
    output logic [LINE_W-1:0]    line_rdata,
    output logic                 line_resp,
    burst_line_adaptor_if.master mem
);

    localparam int BEATS = calc_beats(LINE_W, WORD_W);
    localparam int IDX_W = calc_idx_w(BEATS);
    localparam int OFS   = calc_ofs(LINE_W);

    localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((1 << OFS) - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(WORD_W / 8);
    localparam logic [IDX_W-1:0]  LAST     = IDX_W'(BEATS - 1);

    if ((LINE_W % WORD_W) != 0 || (WORD_W % 8) != 0) begin : g_bad_params
        $error("burst_line_adaptor: bad LINE_W/WORD_W combination");
    end

    adaptor_state_t    state_q, state_d;
    logic [IDX_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              load_en;
    logic              wr_en;
    logic              busy;
    logic [WORD_W-1:0] rd_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        load_en = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (line_read || line_write) begin
                    base_d  = line_addr & ~OFS_MASK;
                    beat_d  = '0;
                    state_d = line_read ? READ : WRITE;
                    load_en = !line_read;
                end
            end
            READ, WRITE: begin
                if (mem.mem_resp) begin
                    wr_en = (state_q == READ);
                    if (beat_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    line_buffer #(
        .LINE_W(LINE_W),
        .WORD_W(WORD_W)
    ) u_buf (
        .clk      (clk),
        .clr      (rst),
        .load_en  (load_en),
        .load_data(line_wdata),
        .wr_en    (wr_en),
        .wr_idx   (beat_q),
        .wr_data  (mem.mem_rdata),
        .rd_idx   (beat_q),
        .rd_data  (rd_word),
        .line     (line_rdata)
    );

    // Memory outputs decode registered state only; no path from line_* inputs.
    assign busy                = (state_q == READ) || (state_q == WRITE);
    assign mem.mem_read        = (state_q == READ);
    assign mem.mem_write       = (state_q == WRITE);
    assign mem.mem_address     = busy ? base_q + ADDR_W'(beat_q) * STRIDE : '0;
    assign mem.mem_wdata       = (state_q == WRITE) ? rd_word : '0;
    assign mem.mem_byte_enable = busy ? '1 : '0;
    assign line_resp           = (state_q == DONE);

endmodule

// File: tb/tb_burst_line_adaptor.sv
// Directed bench for burst_line_adaptor: default 256/32 instance
// plus a 128/64 instance for the wrap-area parametrised read.
module tb_burst_line_adaptor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         line_read, line_write;
    logic [31:0]  line_addr;
    logic [255:0] line_wdata, line_rdata;
    logic         line_resp;

    logic         p_line_read, p_line_write;
    logic [31:0]  p_line_addr;
    logic [127:0] p_line_wdata, p_line_rdata;
    logic         p_line_resp;

    int tests_run = 0;
    int tests_failed = 0;

    burst_line_adaptor_if #(.ADDR_W(32), .WORD_W(32)) mem ();
    burst_line_adaptor_if #(.ADDR_W(32), .WORD_W(64)) mem_p ();

    burst_line_adaptor dut (
        .clk(clk), .rst(rst),
        .line_read(line_read), .line_write(line_write),
        .line_addr(line_addr), .line_wdata(line_wdata),
        .line_rdata(line_rdata), .line_resp(line_resp),
        .mem(mem)
    );

    burst_line_adaptor #(.LINE_W(128), .WORD_W(64), .ADDR_W(32)) dut_p (
        .clk(clk), .rst(rst),
        .line_read(p_line_read), .line_write(p_line_write),
        .line_addr(p_line_addr), .line_wdata(p_line_wdata),
        .line_rdata(p_line_rdata), .line_resp(p_line_resp),
        .mem(mem_p)
    );

    // Memory model for the default instance
    int          waits = 0;
    logic [31:0] rd_base = 32'h0;
    int          wait_cnt = 0;
    logic [31:0] hold_addr = 32'h0;
    int          hold_err = 0;
    int          rd_seen = 0;
    int          wr_seen = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic        log_we[$];
    logic [3:0]  log_be[$];

    always @(negedge clk) begin
        if (mem.mem_read || mem.mem_write) begin
            if (mem.mem_read) rd_seen++;
            if (mem.mem_write) wr_seen++;
            if (wait_cnt == 0) hold_addr = mem.mem_address;
            else if (mem.mem_address !== hold_addr) hold_err++;
            if (wait_cnt < waits) begin
                wait_cnt++;
                mem.mem_resp = 1'b0;
            end else begin
                wait_cnt = 0;
                mem.mem_resp = 1'b1;
                mem.mem_rdata = rd_base + 32'(mem.mem_address[4:2]);
                log_addr.push_back(mem.mem_address);
                log_wdata.push_back(mem.mem_wdata);
                log_we.push_back(mem.mem_write);
                log_be.push_back(mem.mem_byte_enable);
            end
        end else begin
            wait_cnt = 0;
            mem.mem_resp = 1'b0;
            mem.mem_rdata = 32'h0;
        end
    end

    // Zero-wait memory model for the 128/64 instance
    logic [31:0] p_log_addr[$];
    logic [7:0]  p_log_be[$];

    always @(negedge clk) begin
        if (mem_p.mem_read || mem_p.mem_write) begin
            mem_p.mem_resp = 1'b1;
            mem_p.mem_rdata = 64'hC0DE_0000_0000_0000 + 64'(mem_p.mem_address[3]);
            p_log_addr.push_back(mem_p.mem_address);
            p_log_be.push_back(mem_p.mem_byte_enable);
        end else begin
            mem_p.mem_resp = 1'b0;
            mem_p.mem_rdata = 64'h0;
        end
    end

    task automatic clear_logs();
        log_addr.delete();
        log_wdata.delete();
        log_we.delete();
        log_be.delete();
        hold_err = 0;
        rd_seen = 0;
        wr_seen = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        line_read = 1'b0; line_write = 1'b0;
        line_addr = 32'h0; line_wdata = '0;
        p_line_read = 1'b0; p_line_write = 1'b0;
        p_line_addr = 32'h0; p_line_wdata = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (mem.mem_read !== 1'b0 || mem.mem_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_strobe: rd=%b wr=%b want 0 0", mem.mem_read, mem.mem_write);
        end
        tests_run++;
        if (mem.mem_address !== 32'h0 || mem.mem_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_addr_data: addr=%h wdata=%h want 0 0", mem.mem_address, mem.mem_wdata);
        end
        tests_run++;
        if (mem.mem_byte_enable !== 4'h0 || line_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_be_resp: be=%h resp=%b want 0 0", mem.mem_byte_enable, line_resp);
        end
        tests_run++;
        if (line_rdata !== 256'h0 || p_line_rdata !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata: rdata=%h p_rdata=%h want 0", line_rdata, p_line_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_read_zero_wait();
        int k;
        logic [255:0] exp;
        clear_logs();
        waits = 0;
        rd_base = 32'hA000_0000;
        line_addr = 32'h0000_1234;
        line_read = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (line_resp !== 1'b1 && k < 100);
        line_read = 1'b0;
        tests_run++;
        if (k != 9) begin
            tests_failed++;
            $display("FAIL read0_latency: line_resp at t+%0d want t+9", k);
        end
        for (int i = 0; i < 8; i++) exp[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        tests_run++;
        if (line_rdata !== exp) begin
            tests_failed++;
            $display("FAIL read0_rdata: got %h want %h", line_rdata, exp);
        end
        tests_run++;
        if (log_addr.size() != 8) begin
            tests_failed++;
            $display("FAIL read0_beats: got %0d beats want 8", log_addr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests_run++;
                if (log_addr[i] !== 32'h1220 + 32'(4 * i) || log_be[i] !== 4'hF || log_we[i] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL read0_beat%0d: addr=%h be=%h we=%b want %h f 0",
                             i, log_addr[i], log_be[i], log_we[i], 32'h1220 + 32'(4 * i));
                end
            end
        end
        @(negedge clk);
        tests_run++;
        if (line_resp !== 1'b0 || line_rdata !== exp) begin
            tests_failed++;
            $display("FAIL read0_pulse_hold: resp=%b rdata=%h want 0 %h", line_resp, line_rdata, exp);
        end
    endtask

    task automatic test_write_waits();
        int k;
        clear_logs();
        waits = 2;
        for (int i = 0; i < 8; i++) line_wdata[i*32 +: 32] = 32'h1111_1111 * 32'(i + 1);
        line_addr = 32'h0000_201C;
        line_write = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (line_resp !== 1'b1 && k < 100);
        line_write = 1'b0;
        tests_run++;
        if (k != 25) begin
            tests_failed++;
            $display("FAIL write_latency: line_resp at t+%0d want t+25", k);
        end
        tests_run++;
        if (hold_err != 0 || rd_seen != 0 || wr_seen != 24) begin
            tests_failed++;
            $display("FAIL write_hold: hold_err=%0d rd=%0d wr_cycles=%0d want 0 0 24",
                     hold_err, rd_seen, wr_seen);
        end
        tests_run++;
        if (log_addr.size() != 8) begin
            tests_failed++;
            $display("FAIL write_beats: got %0d beats want 8", log_addr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests_run++;
                if (log_addr[i] !== 32'h2000 + 32'(4 * i) ||
                    log_wdata[i] !== 32'h1111_1111 * 32'(i + 1) || log_we[i] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL write_beat%0d: addr=%h wdata=%h we=%b want %h %h 1", i,
                             log_addr[i], log_wdata[i], log_we[i],
                             32'h2000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
                end
            end
        end
        waits = 0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int k;
        logic [255:0] exp;
        clear_logs();
        waits = 0;
        rd_base = 32'hE000_0000;
        line_addr = 32'h0000_3000;
        line_wdata = {8{32'hDEAD_BEEF}};
        line_read = 1'b1;
        line_write = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (line_resp !== 1'b1 && k < 100);
        line_read = 1'b0;
        line_write = 1'b0;
        for (int i = 0; i < 8; i++) exp[i*32 +: 32] = 32'hE000_0000 + 32'(i);
        tests_run++;
        if (k != 9 || wr_seen != 0 || rd_seen != 8) begin
            tests_failed++;
            $display("FAIL both_req: resp t+%0d wr=%0d rd=%0d want 9 0 8", k, wr_seen, rd_seen);
        end
        tests_run++;
        if (line_rdata !== exp) begin
            tests_failed++;
            $display("FAIL both_rdata: got %h want %h", line_rdata, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        int k;
        int resp_seen;
        logic [255:0] exp;
        clear_logs();
        waits = 0;
        rd_base = 32'hB000_0000;
        line_addr = 32'h0000_4000;
        line_read = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        line_read = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem.mem_read !== 1'b0 || mem.mem_address !== 32'h0 || line_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_outputs: rd=%b addr=%h resp=%b want 0 0 0",
                     mem.mem_read, mem.mem_address, line_resp);
        end
        tests_run++;
        if (line_rdata !== 256'h0) begin
            tests_failed++;
            $display("FAIL abort_rdata: got %h want 0", line_rdata);
        end
        rst = 1'b0;
        resp_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (line_resp === 1'b1 || mem.mem_read === 1'b1) resp_seen++;
        end
        tests_run++;
        if (resp_seen != 0) begin
            tests_failed++;
            $display("FAIL abort_quiet: %0d active cycles want 0", resp_seen);
        end
        rd_base = 32'hB100_0000;
        line_addr = 32'h0000_5000;
        line_read = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (line_resp !== 1'b1 && k < 100);
        line_read = 1'b0;
        for (int i = 0; i < 8; i++) exp[i*32 +: 32] = 32'hB100_0000 + 32'(i);
        tests_run++;
        if (k != 9 || line_rdata !== exp) begin
            tests_failed++;
            $display("FAIL abort_retry: resp t+%0d rdata=%h want 9 %h", k, line_rdata, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_param_wrap();
        int k;
        p_log_addr.delete();
        p_log_be.delete();
        p_line_addr = 32'hFFFF_FFF0;
        p_line_read = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (p_line_resp !== 1'b1 && k < 100);
        p_line_read = 1'b0;
        tests_run++;
        if (k != 3) begin
            tests_failed++;
            $display("FAIL param_latency: line_resp at t+%0d want t+3", k);
        end
        tests_run++;
        if (p_log_addr.size() != 2) begin
            tests_failed++;
            $display("FAIL param_beats: got %0d beats want 2", p_log_addr.size());
        end else begin
            tests_run++;
            if (p_log_addr[0] !== 32'hFFFF_FFF0 || p_log_addr[1] !== 32'hFFFF_FFF8 ||
                p_log_be[0] !== 8'hFF || p_log_be[1] !== 8'hFF) begin
                tests_failed++;
                $display("FAIL param_addr: %h %h be %h %h want fffffff0 fffffff8 ff ff",
                         p_log_addr[0], p_log_addr[1], p_log_be[0], p_log_be[1]);
            end
        end
        tests_run++;
        if (p_line_rdata !== {64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0000}) begin
            tests_failed++;
            $display("FAIL param_rdata: got %h want c0de000000000001c0de000000000000", p_line_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k;
        int idle_act;
        clear_logs();
        waits = 0;
        rd_base = 32'hD000_0000;
        line_addr = 32'h0000_6000;
        line_read = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (line_resp !== 1'b1 && k < 100);
        tests_run++;
        if (k != 9 || rd_seen != 8) begin
            tests_failed++;
            $display("FAIL b2b_read: resp t+%0d rd=%0d want 9 8", k, rd_seen);
        end
        @(negedge clk);
        tests_run++;
        if (line_resp !== 1'b0 || mem.mem_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_done_ignored: resp=%b rd=%b want 0 0", line_resp, mem.mem_read);
        end
        clear_logs();
        line_read = 1'b0;
        line_write = 1'b1;
        line_addr = 32'h0000_7000;
        for (int i = 0; i < 8; i++) line_wdata[i*32 +: 32] = 32'hF0F0_0000 + 32'(i);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (line_resp !== 1'b1 && k < 100);
        tests_run++;
        if (k != 9 || rd_seen != 0 || log_addr.size() != 8) begin
            tests_failed++;
            $display("FAIL b2b_write: resp t+%0d rd=%0d beats=%0d want 9 0 8", k, rd_seen, log_addr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests_run++;
                if (log_addr[i] !== 32'h7000 + 32'(4 * i) || log_we[i] !== 1'b1 ||
                    log_wdata[i] !== 32'hF0F0_0000 + 32'(i)) begin
                    tests_failed++;
                    $display("FAIL b2b_beat%0d: addr=%h wdata=%h we=%b", i,
                             log_addr[i], log_wdata[i], log_we[i]);
                end
            end
        end
        @(negedge clk);
        line_write = 1'b0;
        idle_act = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem.mem_read === 1'b1 || mem.mem_write === 1'b1 || line_resp === 1'b1) idle_act++;
        end
        tests_run++;
        if (idle_act != 0) begin
            tests_failed++;
            $display("FAIL b2b_stale: %0d active idle cycles want 0", idle_act);
        end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_waits();
        test_simultaneous();
        test_reset_mid_burst();
        test_param_wrap();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
